// File: rtl/axis_stream_sink_store_pkg.sv
// Shared definitions for the stream sink: FSM state encoding and buffer depth helper.
package axis_stream_sink_store_pkg;

  typedef enum logic [1:0] {
    SinkIdle = 2'd0,
    SinkRecv = 2'd1,
    SinkDone = 2'd2
  } sink_state_e;

  function automatic int unsigned sink_depth(input int unsigned idx_width);
    return 32'd1 << idx_width;
  endfunction

endpackage

// File: rtl/axis_sink_ram.sv
// Simple dual-port buffer: one write port, one registered read-first read port.
module axis_sink_ram
  import axis_stream_sink_store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned STORAGE_IDX_WIDTH = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  logic [STORAGE_IDX_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic                         rd_en_i,
  input  logic [STORAGE_IDX_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o
);

  localparam int unsigned Depth = sink_depth(STORAGE_IDX_WIDTH);

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Non-blocking read of the array yields the pre-write word on a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_stream_sink_store.sv
// AXI-Stream sink that captures one frame into a local buffer and reports count/keep/overflow.
module axis_stream_sink_store
  import axis_stream_sink_store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned STORAGE_IDX_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        S_AXI_TDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_TKEEP,
  input  logic                         S_AXI_TVALID,
  output logic                         S_AXI_TREADY,
  input  logic                         S_AXI_TLAST,
  input  logic                         arm,
  output logic                         busy,
  output logic                         done,
  output logic [STORAGE_IDX_WIDTH:0]   beat_count,
  output logic [DATA_WIDTH/8-1:0]      last_keep,
  output logic                         overflow,
  input  logic                         rd_en,
  input  logic [STORAGE_IDX_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid
);

  localparam int unsigned KeepWidth = DATA_WIDTH / 8;

  sink_state_e                state_q;
  logic [STORAGE_IDX_WIDTH:0] beat_count_q;
  logic [KeepWidth-1:0]       last_keep_q;
  logic                       overflow_q;
  logic                       rd_valid_q;

  logic handshake;
  logic full;
  logic wr_en;

  // Ready comes from the registered state only, never from TVALID.
  assign handshake = S_AXI_TVALID && (state_q == SinkRecv);
  // Count saturates at DEPTH, so its MSB alone marks a full buffer.
  assign full      = beat_count_q[STORAGE_IDX_WIDTH];
  assign wr_en     = handshake && !full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SinkIdle;
      beat_count_q <= '0;
      last_keep_q  <= '0;
      overflow_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      unique case (state_q)
        SinkIdle, SinkDone: begin
          if (arm) begin
            state_q      <= SinkRecv;
            beat_count_q <= '0;
            last_keep_q  <= '0;
            overflow_q   <= 1'b0;
          end
        end
        SinkRecv: begin
          if (handshake) begin
            if (full) begin
              overflow_q <= 1'b1;
            end else begin
              beat_count_q <= beat_count_q + 1'b1;
            end
            if (S_AXI_TLAST) begin
              last_keep_q <= S_AXI_TKEEP;
              state_q     <= SinkDone;
            end
          end
        end
        default: state_q <= SinkIdle;
      endcase
    end
  end

  axis_sink_ram #(
    .DATA_WIDTH       (DATA_WIDTH),
    .STORAGE_IDX_WIDTH(STORAGE_IDX_WIDTH)
  ) u_ram (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wr_en_i  (wr_en),
    .wr_addr_i(beat_count_q[STORAGE_IDX_WIDTH-1:0]),
    .wr_data_i(S_AXI_TDATA),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  assign S_AXI_TREADY = (state_q == SinkRecv);
  assign busy         = (state_q == SinkRecv);
  assign done         = (state_q == SinkDone);
  assign beat_count   = beat_count_q;
  assign last_keep    = last_keep_q;
  assign overflow     = overflow_q;
  assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_axis_stream_sink_store.sv
// Drives a 16-deep and a 4-deep sink with the same stream and checks both against a frame model.
module tb_axis_stream_sink_store;

  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int IDX_B = 4;
  localparam int IDX_S = 2;
  localparam int DEP_B = 16;
  localparam int DEP_S = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [DW-1:0]   tdata = '0;
  logic [KW-1:0]   tkeep = '0;
  logic            tvalid = 1'b0;
  logic            tlast = 1'b0;
  logic            arm = 1'b0;
  logic            rd_en = 1'b0;
  logic [IDX_B-1:0] rd_addr = '0;

  logic            tready_b, busy_b, done_b, overflow_b, rd_valid_b;
  logic [IDX_B:0]  beat_count_b;
  logic [KW-1:0]   last_keep_b;
  logic [DW-1:0]   rd_data_b;
  logic            tready_s, busy_s, done_s, overflow_s, rd_valid_s;
  logic [IDX_S:0]  beat_count_s;
  logic [KW-1:0]   last_keep_s;
  logic [DW-1:0]   rd_data_s;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem_b [DEP_B];
  logic [DW-1:0] mem_s [DEP_S];
  logic [DW-1:0] dq [$];
  logic [KW-1:0] kq [$];

  always #5 clk = ~clk;

  axis_stream_sink_store #(.DATA_WIDTH(DW), .STORAGE_IDX_WIDTH(IDX_B)) dut_b (
    .clk(clk), .reset(reset), .S_AXI_TDATA(tdata), .S_AXI_TKEEP(tkeep),
    .S_AXI_TVALID(tvalid), .S_AXI_TREADY(tready_b), .S_AXI_TLAST(tlast), .arm(arm),
    .busy(busy_b), .done(done_b), .beat_count(beat_count_b), .last_keep(last_keep_b),
    .overflow(overflow_b), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b)
  );

  axis_stream_sink_store #(.DATA_WIDTH(DW), .STORAGE_IDX_WIDTH(IDX_S)) dut_s (
    .clk(clk), .reset(reset), .S_AXI_TDATA(tdata), .S_AXI_TKEEP(tkeep),
    .S_AXI_TVALID(tvalid), .S_AXI_TREADY(tready_s), .S_AXI_TLAST(tlast), .arm(arm),
    .busy(busy_s), .done(done_s), .beat_count(beat_count_s), .last_keep(last_keep_s),
    .overflow(overflow_s), .rd_en(rd_en), .rd_addr(rd_addr[IDX_S-1:0]), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_busy_b", busy_b, 1);
    check("arm_busy_s", busy_s, 1);
    check("arm_tready_b", tready_b, 1);
    check("arm_tready_s", tready_s, 1);
    check("arm_done_b", done_b, 0);
    check("arm_count_b", beat_count_b, 0);
    check("arm_count_s", beat_count_s, 0);
    check("arm_ovf_s", overflow_s, 0);
    check("arm_keep_b", last_keep_b, 0);
  endtask

  // Beats come from dq/kq when supplied, otherwise random; gaps of 1..max_gap idle cycles.
  task automatic send_frame(input int n, input int max_gap, input bit rf_check);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [DW-1:0] old_b, old_s;
    int gap;
    k = '0;
    for (int i = 0; i < n; i++) begin
      gap = (max_gap == 0 || i == 0) ? 0 : $urandom_range(max_gap, 1);
      repeat (gap) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = $urandom;
        step();
      end
      d = (i < dq.size()) ? dq[i] : DW'($urandom);
      k = (i < kq.size()) ? kq[i] : KW'($urandom);
      tvalid = 1'b1;
      tdata  = d;
      tkeep  = k;
      tlast  = (i == n - 1);
      check("tready_b", tready_b, 1);
      check("tready_s", tready_s, 1);
      if (rf_check && i == 0) begin
        rd_en   = 1'b1;
        rd_addr = '0;
        old_b   = mem_b[0];
        old_s   = mem_s[0];
      end
      step();
      if (i < DEP_B) mem_b[i] = d;
      if (i < DEP_S) mem_s[i] = d;
      if (rf_check && i == 0) begin
        check("rdfirst_b", rd_data_b, old_b);
        check("rdfirst_s", rd_data_s, old_s);
        rd_en = 1'b0;
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    check("end_done_b", done_b, 1);
    check("end_done_s", done_s, 1);
    check("end_tready_b", tready_b, 0);
    check("end_tready_s", tready_s, 0);
    check("end_busy_b", busy_b, 0);
    check("end_count_b", beat_count_b, (n < DEP_B) ? n : DEP_B);
    check("end_count_s", beat_count_s, (n < DEP_S) ? n : DEP_S);
    check("end_ovf_b", overflow_b, n > DEP_B);
    check("end_ovf_s", overflow_s, n > DEP_S);
    check("end_keep_b", last_keep_b, k);
    check("end_keep_s", last_keep_s, k);
    dq.delete();
    kq.delete();
  endtask

  task automatic read_word(input int a);
    rd_en   = 1'b1;
    rd_addr = IDX_B'(a);
    step();
    rd_en = 1'b0;
    check("rd_valid_b", rd_valid_b, 1);
    check("rd_valid_s", rd_valid_s, 1);
    check("rd_data_b", rd_data_b, mem_b[a % DEP_B]);
    check("rd_data_s", rd_data_s, mem_s[a % DEP_S]);
    step();
    check("rd_idle_b", rd_valid_b, 0);
    check("rd_hold_b", rd_data_b, mem_b[a % DEP_B]);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEP_B; i++) mem_b[i] = 'x;
    for (int i = 0; i < DEP_S; i++) mem_s[i] = 'x;

    // Reset state
    step();
    step();
    check("rst_tready_b", tready_b, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_done_b", done_b, 0);
    check("rst_ovf_b", overflow_b, 0);
    check("rst_rdv_b", rd_valid_b, 0);
    check("rst_count_b", beat_count_b, 0);
    check("rst_keep_b", last_keep_b, 0);
    check("rst_rdata_b", rd_data_b, 0);
    check("rst_tready_s", tready_s, 0);
    check("rst_count_s", beat_count_s, 0);
    reset = 1'b1;
    step();

    // Valid offered while idle is not accepted
    tvalid = 1'b1;
    repeat (10) begin
      tdata = $urandom;
      step();
      check("idle_tready_b", tready_b, 0);
      check("idle_count_b", beat_count_b, 0);
    end
    tvalid = 1'b0;
    do_arm();

    // Directed 4-beat frame
    dq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    kq = '{4'hF, 4'hF, 4'hF, 4'h3};
    send_frame(4, 0, 1'b0);
    for (int a = 0; a < 4; a++) read_word(a);

    // Gapped 6-beat frame; overflows the small sink; read-first collision on addr 0
    do_arm();
    send_frame(6, 1, 1'b1);
    for (int a = 0; a < 6; a++) read_word(a);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      do_arm();
      n = $urandom_range(20, 1);
      send_frame(n, 3, 1'b0);
      for (int r = 0; r < 3; r++) read_word($urandom_range(((n < DEP_B) ? n : DEP_B) - 1, 0));
    end

    // Reset in the middle of a frame
    do_arm();
    for (int i = 0; i < 2; i++) begin
      tvalid = 1'b1;
      tdata  = $urandom;
      tlast  = 1'b0;
      step();
      mem_b[i] = tdata;
      mem_s[i] = tdata;
    end
    tdata = $urandom;
    reset = 1'b0;
    #1;
    check("midrst_tready_b", tready_b, 0);
    check("midrst_tready_s", tready_s, 0);
    check("midrst_busy_b", busy_b, 0);
    check("midrst_count_b", beat_count_b, 0);
    tvalid = 1'b0;
    step();
    reset = 1'b1;
    step();
    do_arm();
    dq = '{32'h55};
    send_frame(1, 0, 1'b0);
    read_word(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_stream_sink_store.md
Name: axis_stream_sink_store

Overview:
- AXI-Stream slave that accepts one frame (through TLAST) into a local buffer of 2^STORAGE_IDX_WIDTH words.
- Receive end for the stream masters in the DFX sequencer streaming path.
- A control/sequencer agent arms it, polls `done`, then reads captured words back through a synchronous read port.
- Provides beat count, final-beat TKEEP and overflow status for checking.

Parameters:
- DATA_WIDTH, 32, stream and storage word width in bits; multiple of 8.
- STORAGE_IDX_WIDTH, 10, buffer address width; depth DEPTH = 2^STORAGE_IDX_WIDTH words.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- S_AXI_TDATA  in  DATA_WIDTH  stream data.
- S_AXI_TKEEP  in  DATA_WIDTH/8  byte enables.
- S_AXI_TVALID  in  1  beat valid.
- S_AXI_TREADY  out  1  sink ready.
- S_AXI_TLAST  in  1  final beat of frame.
- arm  in  1  one-cycle pulse; starts a capture.
- busy  out  1  high while capturing (state RECV).
- done  out  1  high from frame end until next arm.
- beat_count  out  STORAGE_IDX_WIDTH+1  accepted beats this frame, saturating at DEPTH.
- last_keep  out  DATA_WIDTH/8  TKEEP of the TLAST beat.
- overflow  out  1  frame exceeded DEPTH beats.
- rd_en  in  1  read request.
- rd_addr  in  STORAGE_IDX_WIDTH  read word address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data valid.

Behaviour:
- Reset (reset==0, async assert, sync deassert assumed upstream):
  - state=IDLE; S_AXI_TREADY, busy, done, overflow, rd_valid all 0.
  - beat_count, last_keep, rd_data all 0.
  - Buffer contents are not reset.
- FSM states: IDLE, RECV, DONE. S_AXI_TREADY = (state==RECV), decoded from the registered state only, with no combinational path from TVALID.
- IDLE:
  - arm=1 → RECV next cycle; clear beat_count, overflow, last_keep and done.
  - TVALID is ignored (TREADY=0).
- RECV:
  - Handshake is TVALID&TREADY.
  - On handshake with beat_count<DEPTH: write TDATA to mem[beat_count[IDX-1:0]]; beat_count+1.
  - On handshake with beat_count==DEPTH: data is dropped, overflow←1, beat_count holds at DEPTH. Beats are still accepted so the frame drains.
  - Handshake with TLAST=1: last_keep←TKEEP; state→DONE; TREADY is low from the next cycle. The TLAST beat itself is stored and counted as above.
  - arm while in RECV is ignored.
- DONE:
  - done=1, TREADY=0.
  - arm=1 → RECV with the same clears as from IDLE; done falls the cycle after arm.
- TKEEP does not mask buffer writes; full words are stored and only the final-beat TKEEP is reported.
- Single-beat frame (TLAST on first beat): beat_count=1, DONE.
- Read port:
  - rd_en at cycle N → rd_data = mem[rd_addr] and rd_valid=1 at N+1. rd_valid=0 when rd_en=0; rd_data holds its last value.
  - Legal in any state.
  - Same-cycle write and read to the same address returns the old data (read-first).
- Reset mid-frame: immediately IDLE with all outputs at reset values. The upstream master must drop or restart its frame.

Decomposition:
- Shared package (streamer common):
  - FSM state encoding constants SINK_IDLE=2'd0, SINK_RECV=2'd1, SINK_DONE=2'd2.
  - DEPTH derivation helper from STORAGE_IDX_WIDTH.
- One sub-module, axis_sink_ram: simple dual-port RAM with one write port and one synchronous read-first read port, parameterised by DATA_WIDTH and STORAGE_IDX_WIDTH, inferable as BRAM. The top holds the FSM, counters and status.

Test Plan:
- Reset → all outputs 0.
- 4-beat frame:
  - Stimulus: arm; TDATA 0xA0..0xA3 back-to-back, TLAST on beat 3, TKEEP=0x3 on beat 3.
  - Expected: beat_count=4, last_keep=0x3, done=1, overflow=0.
  - Readback at addresses 0..3 returns 0xA0..0xA3, each with rd_valid one cycle after rd_en.
- Backpressure-free gapped valid:
  - Stimulus: TVALID toggled 1/0 over 6 beats.
  - Expected: only handshaken beats are counted, giving beat_count=6 and memory contiguous.
- Overflow (STORAGE_IDX_WIDTH=2):
  - Stimulus: 6-beat frame.
  - Expected: beat_count=4, overflow=1, done=1; mem holds beats 0..3; TREADY stayed 1 until TLAST.
- Not armed:
  - Stimulus: TVALID=1 in IDLE for 10 cycles.
  - Expected: TREADY=0, beat_count=0.
  - Stimulus: then arm.
  - Expected: TREADY=1 the next cycle.
- Reset mid-frame:
  - Stimulus: assert reset after 2 of 5 beats.
  - Expected: TREADY=0 and busy=0 immediately.
  - Stimulus: re-arm after reset release; single-beat frame 0x55 with TLAST.
  - Expected: beat_count=1, mem[0]=0x55.
